// File: rtl/rvv_backend_dispatch_credit_ctrl.sv
// ---------------------------------------------------------------------------
// rvv_backend_dispatch_credit_ctrl
//
// Credit-based dispatch controller between the uop queue and the per-unit
// reservation stations / ROB. Each execution unit has a registered credit
// counter that mirrors its free RS entries, so acceptance needs no ready
// signal from the RS. Up to NUM_DP uops are accepted per cycle as an
// in-order prefix.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   uop_valid_uop2dp    per-lane valid from the uop queue
//   uop_hazard          per-lane unresolved RAW wait
//   vr_limit            architectural hazard, blocks the last lane only
//   uop_unit            per-lane one-hot target unit (lane i at i*NUM_UNIT)
//   uop_rob_skip        per-lane "takes no ROB entry"
//   rob_free_cnt        free ROB slots this cycle (saturated at NUM_DP)
//   rs_release          per-unit count of RS entries freed this cycle
//   flush               synchronous pipeline flush
//   uop_ready_dp2uop    per-lane accept (pop)
//   rs_valid_dp2rs      per-lane, per-unit RS write strobe
//   uop_valid_dp2rob    per-lane ROB write strobe
//   credit              registered credits, unit u at u*CW
//   stall_cnt           saturating count of head-stall cycles
//   credit_err          sticky release-overflow flag
// ---------------------------------------------------------------------------
module rvv_backend_dispatch_credit_ctrl #(
  parameter int NUM_DP   = 4,
  parameter int NUM_UNIT = 5,
  parameter int RS_DEPTH = 8,
  parameter int CW       = $clog2(RS_DEPTH + 1),
  parameter int RW       = $clog2(NUM_DP + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DP-1:0]          uop_valid_uop2dp,
  input  logic [NUM_DP-1:0]          uop_hazard,
  input  logic                       vr_limit,
  input  logic [NUM_DP*NUM_UNIT-1:0] uop_unit,
  input  logic [NUM_DP-1:0]          uop_rob_skip,
  input  logic [RW-1:0]              rob_free_cnt,
  input  logic [NUM_UNIT*RW-1:0]     rs_release,
  input  logic                       flush,
  output logic [NUM_DP-1:0]          uop_ready_dp2uop,
  output logic [NUM_DP*NUM_UNIT-1:0] rs_valid_dp2rs,
  output logic [NUM_DP-1:0]          uop_valid_dp2rob,
  output logic [NUM_UNIT*CW-1:0]     credit,
  output logic [15:0]                stall_cnt,
  output logic                       credit_err
);

  // Wide enough for credit + release without wrap before clamping.
  localparam int W = CW + RW + 1;

  logic [NUM_UNIT-1:0][CW-1:0] credit_q, credit_d;
  logic                        credit_err_q, credit_err_d;
  logic [15:0]                 stall_q, stall_d;

  logic [NUM_DP-1:0]           acc;
  logic [NUM_UNIT-1:0][RW-1:0] demand;
  logic [RW-1:0]               rob_demand;
  logic [NUM_UNIT-1:0]         lane_unit;
  logic                        run;
  logic                        lane_ok;

  logic [NUM_UNIT-1:0][RW-1:0] dispatched;
  logic [NUM_UNIT-1:0][W-1:0]  credit_sum;
  logic [NUM_UNIT-1:0]         overflow;

  // -------------------------------------------------------------------------
  // Acceptance: walk lanes in order with running per-unit and ROB demand.
  // 'run' stays low once any lane fails, so the accepted set is a prefix.
  // -------------------------------------------------------------------------
  always_comb begin
    acc        = '0;
    demand     = '0;
    rob_demand = '0;
    lane_unit  = '0;
    run        = 1'b1;
    lane_ok    = 1'b0;
    for (int unsigned i = 0; i < NUM_DP; i++) begin
      lane_unit = uop_unit[i*NUM_UNIT +: NUM_UNIT];
      // exactly one bit set: non-zero and power of two
      lane_ok   = (lane_unit != '0) && ((lane_unit & (lane_unit - 1'b1)) == '0);
      lane_ok   = lane_ok & uop_valid_uop2dp[i] & ~uop_hazard[i] & ~flush;
      if (i == NUM_DP - 1) begin
        lane_ok = lane_ok & ~vr_limit;
      end
      for (int unsigned u = 0; u < NUM_UNIT; u++) begin
        if (lane_unit[u]) begin
          demand[u] = demand[u] + 1'b1;
        end
        if (W'(demand[u]) > W'(credit_q[u])) begin
          lane_ok = 1'b0;
        end
      end
      if (!uop_rob_skip[i]) begin
        rob_demand = rob_demand + 1'b1;
      end
      if (rob_demand > rob_free_cnt) begin
        lane_ok = 1'b0;
      end
      run    = run & lane_ok;
      acc[i] = run;
    end
  end

  // -------------------------------------------------------------------------
  // Strobes, held low during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    uop_ready_dp2uop = '0;
    uop_valid_dp2rob = '0;
    rs_valid_dp2rs   = '0;
    for (int unsigned i = 0; i < NUM_DP; i++) begin
      uop_ready_dp2uop[i] = acc[i] & rst_n;
      uop_valid_dp2rob[i] = acc[i] & rst_n & ~uop_rob_skip[i];
      rs_valid_dp2rs[i*NUM_UNIT +: NUM_UNIT] =
        uop_unit[i*NUM_UNIT +: NUM_UNIT] & {NUM_UNIT{acc[i] & rst_n}};
    end
  end

  // -------------------------------------------------------------------------
  // Credit next-state. Underflow cannot occur: acceptance bounds dispatch by
  // the current credit, so only the upper bound needs clamping.
  // -------------------------------------------------------------------------
  always_comb begin
    dispatched = '0;
    for (int unsigned i = 0; i < NUM_DP; i++) begin
      for (int unsigned u = 0; u < NUM_UNIT; u++) begin
        if (acc[i] && uop_unit[i*NUM_UNIT + u]) begin
          dispatched[u] = dispatched[u] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    credit_sum   = '0;
    overflow     = '0;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    for (int unsigned u = 0; u < NUM_UNIT; u++) begin
      credit_sum[u] = W'(credit_q[u]) + W'(rs_release[u*RW +: RW]) - W'(dispatched[u]);
      if (credit_sum[u] > W'(RS_DEPTH)) begin
        overflow[u] = 1'b1;
        credit_d[u] = CW'(RS_DEPTH);
      end else begin
        credit_d[u] = credit_sum[u][CW-1:0];
      end
    end
    if (flush) begin
      for (int unsigned u = 0; u < NUM_UNIT; u++) begin
        credit_d[u] = CW'(RS_DEPTH);
      end
    end else if (overflow != '0) begin
      credit_err_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Head-stall counter.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (uop_valid_uop2dp[0] && !acc[0] && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned u = 0; u < NUM_UNIT; u++) begin
        credit_q[u] <= CW'(RS_DEPTH);
      end
      credit_err_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      stall_q      <= stall_d;
    end
  end

  assign credit     = credit_q;
  assign stall_cnt  = stall_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_rvv_backend_dispatch_credit_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for rvv_backend_dispatch_credit_ctrl (default parameters).
// Table of vectors with hand-derived expectations, routed through a
// scoreboard queue, plus stall saturation and mid-run reset sequences.
// ---------------------------------------------------------------------------
module tb_rvv_backend_dispatch_credit_ctrl;

  localparam logic [4:0] ALU  = 5'b00001;
  localparam logic [4:0] PMT  = 5'b00010;
  localparam logic [4:0] MUL  = 5'b00100;
  localparam logic [4:0] DIV  = 5'b01000;
  localparam logic [4:0] LSU  = 5'b10000;
  localparam logic [4:0] NONE = 5'b00000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  uop_valid_uop2dp;
  logic [3:0]  uop_hazard;
  logic        vr_limit;
  logic [19:0] uop_unit;
  logic [3:0]  uop_rob_skip;
  logic [2:0]  rob_free_cnt;
  logic [14:0] rs_release;
  logic        flush;
  logic [3:0]  uop_ready_dp2uop;
  logic [19:0] rs_valid_dp2rs;
  logic [3:0]  uop_valid_dp2rob;
  logic [19:0] credit;
  logic [15:0] stall_cnt;
  logic        credit_err;

  rvv_backend_dispatch_credit_ctrl #(
    .NUM_DP   (4),
    .NUM_UNIT (5),
    .RS_DEPTH (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uop_valid_uop2dp (uop_valid_uop2dp),
    .uop_hazard       (uop_hazard),
    .vr_limit         (vr_limit),
    .uop_unit         (uop_unit),
    .uop_rob_skip     (uop_rob_skip),
    .rob_free_cnt     (rob_free_cnt),
    .rs_release       (rs_release),
    .flush            (flush),
    .uop_ready_dp2uop (uop_ready_dp2uop),
    .rs_valid_dp2rs   (rs_valid_dp2rs),
    .uop_valid_dp2rob (uop_valid_dp2rob),
    .credit           (credit),
    .stall_cnt        (stall_cnt),
    .credit_err       (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  valid;
    logic [3:0]  hazard;
    logic        vrl;
    logic [19:0] unit;
    logic [3:0]  skip;
    logic [2:0]  robfree;
    logic [14:0] rel;
    logic        fl;
    logic [3:0]  exp_ready;
    logic [19:0] exp_credit;
    logic [15:0] exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];
  vec_t sb[$];
  int   n_checks;
  int   n_fail;

  function automatic logic [19:0] lanes(logic [4:0] l0, logic [4:0] l1,
                                        logic [4:0] l2, logic [4:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [14:0] rel(int a, int p, int m, int d, int l);
    return {3'(l), 3'(d), 3'(m), 3'(p), 3'(a)};
  endfunction

  function automatic logic [19:0] crd(int a, int p, int m, int d, int l);
    return {4'(l), 4'(d), 4'(m), 4'(p), 4'(a)};
  endfunction

  function automatic vec_t mk(string name, logic [3:0] valid, logic [3:0] hazard,
                              logic vrl, logic [19:0] unit, logic [3:0] skip,
                              logic [2:0] robfree, logic [14:0] r, logic fl,
                              logic [3:0] er, logic [19:0] ec, logic [15:0] es,
                              logic ee);
    vec_t v;
    v.name = name; v.valid = valid; v.hazard = hazard; v.vrl = vrl;
    v.unit = unit; v.skip = skip; v.robfree = robfree; v.rel = r; v.fl = fl;
    v.exp_ready = er; v.exp_credit = ec; v.exp_stall = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    uop_valid_uop2dp = v.valid;
    uop_hazard       = v.hazard;
    vr_limit         = v.vrl;
    uop_unit         = v.unit;
    uop_rob_skip     = v.skip;
    rob_free_cnt     = v.robfree;
    rs_release       = v.rel;
    flush            = v.fl;
  endtask

  task automatic idle_inputs();
    uop_valid_uop2dp = '0;
    uop_hazard       = '0;
    vr_limit         = 1'b0;
    uop_unit         = '0;
    uop_rob_skip     = '0;
    rob_free_cnt     = '0;
    rs_release       = '0;
    flush            = 1'b0;
  endtask

  initial begin
    vec_t        e;
    logic [19:0] exp_rs;
    logic [19:0] a4;
    logic [19:0] m4;
    logic [19:0] mix;

    n_checks = 0;
    n_fail   = 0;
    a4  = lanes(ALU, ALU, ALU, ALU);
    m4  = lanes(MUL, MUL, MUL, MUL);
    mix = lanes(ALU, DIV, ALU, LSU);

    vecs[0]  = mk("idle",      4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0000, crd(8,8,8,8,8), 0, 0);
    vecs[1]  = mk("alu4",      4'b1111, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b1111, crd(8,8,8,8,8), 0, 0);
    vecs[2]  = mk("alu_drain", 4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0000, crd(4,8,8,8,8), 0, 0);
    vecs[3]  = mk("mul4",      4'b1111, 4'b0000, 0, m4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b1111, crd(4,8,8,8,8), 0, 0);
    vecs[4]  = mk("mul_part",  4'b0011, 4'b0000, 0, m4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0011, crd(4,8,4,8,8), 0, 0);
    vecs[5]  = mk("mul_limit", 4'b1111, 4'b0000, 0, m4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0011, crd(4,8,2,8,8), 0, 0);
    vecs[6]  = mk("mul_rel",   4'b1111, 4'b0000, 0, m4, 4'b0000, 4, rel(0,0,3,0,0), 0, 4'b0000, crd(4,8,0,8,8), 0, 0);
    vecs[7]  = mk("mul_after", 4'b1111, 4'b0000, 0, m4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0111, crd(4,8,3,8,8), 1, 0);
    vecs[8]  = mk("hazard",    4'b1111, 4'b0010, 0, mix, 4'b0000, 4, rel(4,0,3,0,0), 0, 4'b0001, crd(4,8,0,8,8), 1, 0);
    vecs[9]  = mk("vr_limit",  4'b1111, 4'b0000, 1, mix, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0111, crd(7,8,3,8,8), 1, 0);
    vecs[10] = mk("rob_skip",  4'b1111, 4'b0000, 0, a4, 4'b0101, 1, rel(0,0,0,0,0), 0, 4'b0111, crd(5,8,3,7,8), 1, 0);
    vecs[11] = mk("onehot0",   4'b1111, 4'b0000, 0, lanes(ALU, NONE, ALU, ALU), 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0001, crd(2,8,3,7,8), 1, 0);
    vecs[12] = mk("multihot",  4'b1111, 4'b0000, 0, lanes(ALU | MUL, ALU, ALU, ALU), 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0000, crd(1,8,3,7,8), 1, 0);
    vecs[13] = mk("rob_zero",  4'b1111, 4'b0000, 0, a4, 4'b1111, 0, rel(0,0,0,0,0), 0, 4'b0001, crd(1,8,3,7,8), 2, 0);
    vecs[14] = mk("flush",     4'b1111, 4'b0000, 0, a4, 4'b0000, 4, rel(2,0,0,0,0), 1, 4'b0000, crd(0,8,3,7,8), 2, 0);
    vecs[15] = mk("post_fl",   4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0000, crd(8,8,8,8,8), 0, 0);
    vecs[16] = mk("overflow",  4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(1,0,0,0,0), 0, 4'b0000, crd(8,8,8,8,8), 0, 0);
    vecs[17] = mk("err_stick", 4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0000, crd(8,8,8,8,8), 0, 1);
    vecs[18] = mk("err_flush", 4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 1, 4'b0000, crd(8,8,8,8,8), 0, 1);
    vecs[19] = mk("err_after", 4'b0000, 4'b0000, 0, a4, 4'b0000, 4, rel(0,0,0,0,0), 0, 4'b0000, crd(8,8,8,8,8), 0, 1);

    // reset with active inputs: strobes must stay low
    rst_n = 1'b0;
    drive(vecs[1]);
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(uop_ready_dp2uop), 32'h0);
    check("rst_rs",     32'(rs_valid_dp2rs),   32'h0);
    check("rst_rob",    32'(uop_valid_dp2rob), 32'h0);
    check("rst_credit", 32'(credit),           32'(crd(8,8,8,8,8)));
    check("rst_stall",  32'(stall_cnt),        32'h0);
    check("rst_err",    32'(credit_err),       32'h0);
    idle_inputs();
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k]);
      sb.push_back(vecs[k]);
      @(negedge clk);
      e = sb.pop_front();
      exp_rs = '0;
      for (int i = 0; i < 4; i++) begin
        if (e.exp_ready[i]) exp_rs[i*5 +: 5] = e.unit[i*5 +: 5];
      end
      check({e.name, ".ready"},  32'(uop_ready_dp2uop), 32'(e.exp_ready));
      check({e.name, ".rs"},     32'(rs_valid_dp2rs),   32'(exp_rs));
      check({e.name, ".rob"},    32'(uop_valid_dp2rob), 32'(e.exp_ready & ~e.skip));
      check({e.name, ".credit"}, 32'(credit),           32'(e.exp_credit));
      check({e.name, ".stall"},  32'(stall_cnt),        32'(e.exp_stall));
      check({e.name, ".err"},    32'(credit_err),       32'(e.exp_err));
    end

    // head-lane hazard held: stall counter saturates at 16'hFFFF
    @(posedge clk);
    #1;
    idle_inputs();
    uop_valid_uop2dp = 4'b0001;
    uop_hazard       = 4'b0001;
    uop_unit         = a4;
    rob_free_cnt     = 3'd4;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("stall_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    @(negedge clk);
    check("stall_ffff", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (4465) @(negedge clk);
    check("stall_sat",  32'(stall_cnt), 32'h0000_FFFF);
    check("stall_rdy",  32'(uop_ready_dp2uop), 32'h0);

    // mid-run async reset while 4 ALU uops are offered
    uop_valid_uop2dp = 4'b1111;
    uop_hazard       = 4'b0000;
    #1;
    check("pre_rst_ready", 32'(uop_ready_dp2uop), 32'hF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready",  32'(uop_ready_dp2uop), 32'h0);
    check("mid_rst_rs",     32'(rs_valid_dp2rs),   32'h0);
    check("mid_rst_rob",    32'(uop_valid_dp2rob), 32'h0);
    check("mid_rst_credit", 32'(credit),           32'(crd(8,8,8,8,8)));
    check("mid_rst_stall",  32'(stall_cnt),        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(uop_ready_dp2uop), 32'hF);
    check("post_rst_rs",    32'(rs_valid_dp2rs),   32'(lanes(ALU, ALU, ALU, ALU)));
    @(negedge clk);
    check("post_rst_credit", 32'(credit), 32'(crd(4,8,8,8,8)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
